// File: rtl/wb_button_unit.sv
// ============================================================================
// Module   : wb_button_unit
// Brief    : Synchronised, debounced controller buttons with sticky read-clear
//            press/release flags for the W-stage sbp read path.
//            Optional release flags: define WB_BTN_RELEASE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_button_unit #(
    parameter int NUM_BTN      = 8,
    parameter int SEL_W        = 3,
    parameter int DEBOUNCE_CYC = 16,
    parameter int CNT_W        = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] raw_btn,
    input  logic               rd_en,
    input  logic [SEL_W-1:0]   rd_sel,
    input  logic [1:0]         rd_mode,
    output logic               rd_val,
    output logic [NUM_BTN-1:0] btn_state,
    output logic [NUM_BTN-1:0] press_pend,
    output logic [NUM_BTN-1:0] rel_pend
);

    localparam logic [1:0]       c_MODE_LEVEL = 2'b00;
    localparam logic [1:0]       c_MODE_PRESS = 2'b01;
    localparam logic [1:0]       c_MODE_REL   = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    logic [NUM_BTN-1:0] r_stable;
    logic [NUM_BTN-1:0] r_press;
    logic [NUM_BTN-1:0] w_accept;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] w_hit;
    logic [NUM_BTN-1:0] w_clr_press;
    logic               w_rel_bit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_btn;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic [CNT_W-1:0] r_cnt;
            logic             w_diff;

            assign w_diff       = r_sync2[gi] ^ r_stable[gi];
            assign w_accept[gi] = w_diff && (r_cnt == c_CNT_LAST);
            // An out-of-range select matches no button, so it reads 0 and clears nothing.
            assign w_hit[gi]    = (rd_sel == SEL_W'(gi));

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (!w_diff || w_accept[gi]) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign w_rise      = w_accept & r_sync2;
    assign w_clr_press = {NUM_BTN{rd_en && (rd_mode == c_MODE_PRESS)}} & w_hit;

    // Set is OR-ed in after the clear mask so a coincident press is never lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stable <= '0;
            r_press  <= '0;
        end else begin
            r_stable <= r_stable ^ w_accept;
            r_press  <= (r_press & ~w_clr_press) | w_rise;
        end
    end

`ifdef WB_BTN_RELEASE_EN
    logic [NUM_BTN-1:0] r_rel;
    logic [NUM_BTN-1:0] w_fall;
    logic [NUM_BTN-1:0] w_clr_rel;

    assign w_fall    = w_accept & ~r_sync2;
    assign w_clr_rel = {NUM_BTN{rd_en && (rd_mode == c_MODE_REL)}} & w_hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rel <= '0;
        end else begin
            r_rel <= (r_rel & ~w_clr_rel) | w_fall;
        end
    end

    assign rel_pend  = r_rel;
    assign w_rel_bit = |(r_rel & w_hit);
`else
    assign rel_pend  = '0;
    assign w_rel_bit = 1'b0;
`endif

    always_comb begin
        rd_val = 1'b0;
        case (rd_mode)
            c_MODE_LEVEL: rd_val = |(r_stable & w_hit);
            c_MODE_PRESS: rd_val = |(r_press & w_hit);
            c_MODE_REL:   rd_val = w_rel_bit;
            default:      rd_val = 1'b0;
        endcase
    end

    assign btn_state  = r_stable;
    assign press_pend = r_press;

endmodule

`default_nettype wire

// File: tb/tb_wb_button_unit.sv
// ============================================================================
// Module   : tb_wb_button_unit
// Brief    : Directed self-checking bench for wb_button_unit (8-button default
//            instance plus a 6-button instance for out-of-range selects).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_button_unit;

    logic       clock;
    logic       reset;
    logic [7:0] raw_btn;
    logic       rd_en;
    logic [2:0] rd_sel;
    logic [1:0] rd_mode;
    logic       rd_val;
    logic [7:0] btn_state;
    logic [7:0] press_pend;
    logic [7:0] rel_pend;

    logic [5:0] raw6;
    logic       rd_en6;
    logic [2:0] rd_sel6;
    logic [1:0] rd_mode6;
    logic       rd_val6;
    logic [5:0] btn_state6;
    logic [5:0] press_pend6;
    logic [5:0] rel_pend6;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef WB_BTN_RELEASE_EN
    localparam logic c_REL_EN = 1'b1;
`else
    localparam logic c_REL_EN = 1'b0;
`endif

    wb_button_unit #(
        .NUM_BTN(8), .SEL_W(3), .DEBOUNCE_CYC(16), .CNT_W(5)
    ) u_dut (
        .clock(clock), .reset(reset), .raw_btn(raw_btn),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_mode(rd_mode),
        .rd_val(rd_val), .btn_state(btn_state),
        .press_pend(press_pend), .rel_pend(rel_pend)
    );

    wb_button_unit #(
        .NUM_BTN(6), .SEL_W(3), .DEBOUNCE_CYC(4), .CNT_W(3)
    ) u_dut6 (
        .clock(clock), .reset(reset), .raw_btn(raw6),
        .rd_en(rd_en6), .rd_sel(rd_sel6), .rd_mode(rd_mode6),
        .rd_val(rd_val6), .btn_state(btn_state6),
        .press_pend(press_pend6), .rel_pend(rel_pend6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset    = 1'b1;
        raw_btn  = 8'hFF;
        rd_en    = 1'b0;
        rd_sel   = 3'd0;
        rd_mode  = 2'b00;
        raw6     = 6'h3F;
        rd_en6   = 1'b0;
        rd_sel6  = 3'd0;
        rd_mode6 = 2'b00;

        // Reset held 3 cycles with all buttons pressed.
        cycles(3);
        check("rst_btn_state", 32'(btn_state), 32'h00);
        check("rst_press_pend", 32'(press_pend), 32'h00);
        check("rst_rel_pend", 32'(rel_pend), 32'h00);
        check("rst_rd_val", 32'(rd_val), 32'h0);
        reset = 1'b0;
        cycles(17);
        check("rst_state_at_17", 32'(btn_state), 32'h00);
        cycles(1);
        check("rst_state_at_18", 32'(btn_state), 32'hFF);
        check("rst_press_at_18", 32'(press_pend), 32'hFF);

        // Re-reset with buttons released to start from a clean slate.
        reset   = 1'b1;
        raw_btn = 8'h00;
        cycles(3);
        check("rst2_press_pend", 32'(press_pend), 32'h00);
        reset = 1'b0;
        cycles(5);

        // Debounce of button 3.
        raw_btn[3] = 1'b1;
        cycles(17);
        check("deb_b3_at_17", 32'(btn_state[3]), 32'h0);
        cycles(1);
        check("deb_b3_at_18", 32'(btn_state[3]), 32'h1);
        check("deb_press_b3", 32'(press_pend), 32'h08);

        // 10-cycle glitch on button 5 is filtered.
        raw_btn[5] = 1'b1;
        cycles(10);
        raw_btn[5] = 1'b0;
        cycles(30);
        check("glitch_b5_state", 32'(btn_state[5]), 32'h0);
        check("glitch_b5_press", 32'(press_pend[5]), 32'h0);

        // Read-clear of the button 3 press flag.
        rd_en = 1'b1; rd_sel = 3'd3; rd_mode = 2'b01;
        #1;
        check("rdclr_val", 32'(rd_val), 32'h1);
        cycles(1);
        rd_en = 1'b0;
        #1;
        check("rdclr_press_b3", 32'(press_pend[3]), 32'h0);
        check("rdclr_reread", 32'(rd_val), 32'h0);
        rd_mode = 2'b00;
        #1;
        check("rdclr_level_b3", 32'(rd_val), 32'h1);
        check("rdclr_state_b3", 32'(btn_state[3]), 32'h1);
        rd_mode = 2'b11;
        #1;
        check("reserved_mode", 32'(rd_val), 32'h0);
        cycles(1);

        // Collision: button 2 debounces on the same edge as its read-clear.
        raw_btn[2] = 1'b1;
        cycles(17);
        rd_en = 1'b1; rd_sel = 3'd2; rd_mode = 2'b01;
        #1;
        check("coll_rd_val", 32'(rd_val), 32'h0);
        cycles(1);
        rd_en = 1'b0;
        check("coll_state_b2", 32'(btn_state[2]), 32'h1);
        check("coll_press_b2", 32'(press_pend[2]), 32'h1);

        // Out-of-range select on the 6-button instance.
        check("oor_state6", 32'(btn_state6), 32'h3F);
        rd_en6 = 1'b1; rd_sel6 = 3'd7; rd_mode6 = 2'b00;
        #1;
        check("oor_sel7_level", 32'(rd_val6), 32'h0);
        rd_mode6 = 2'b01;
        #1;
        check("oor_sel7_press", 32'(rd_val6), 32'h0);
        cycles(1);
        rd_sel6 = 3'd6;
        #1;
        check("oor_sel6_press", 32'(rd_val6), 32'h0);
        cycles(1);
        rd_en6 = 1'b0;
        check("oor_press6_kept", 32'(press_pend6), 32'h3F);
        rd_sel6 = 3'd5; rd_mode6 = 2'b00;
        #1;
        check("inrange_sel5", 32'(rd_val6), 32'h1);

        // Release of button 1 after it has debounced high.
        raw_btn[1] = 1'b1;
        cycles(20);
        check("rel_b1_high", 32'(btn_state[1]), 32'h1);
        raw_btn[1] = 1'b0;
        cycles(17);
        check("rel_b1_at_17", 32'(btn_state[1]), 32'h1);
        check("rel_pend_at_17", 32'(rel_pend), 32'h00);
        cycles(1);
        check("rel_b1_at_18", 32'(btn_state[1]), 32'h0);
        check("rel_pend_at_18", 32'(rel_pend), c_REL_EN ? 32'h02 : 32'h00);
        rd_en = 1'b1; rd_sel = 3'd1; rd_mode = 2'b10;
        #1;
        check("rel_rd_val", 32'(rd_val), c_REL_EN ? 32'h1 : 32'h0);
        cycles(1);
        rd_en = 1'b0;
        #1;
        check("rel_pend_cleared", 32'(rel_pend), 32'h00);
        check("rel_reread", 32'(rd_val), 32'h0);
        check("rel_press_kept", 32'(press_pend), 32'h06);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
